// File: rtl/ascon_serial_engine_if.sv
// Serial load/unload handshake bundle between a host and ascon_serial_engine.
interface ascon_serial_engine_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/ascon_serial_engine.sv
// Serialises key/nonce/AD/text(/tag) into an ASCON core and streams the
// core's ciphertext+tag or plaintext back out W bits at a time.
module ascon_serial_engine #(
    parameter int unsigned KEY_L  = 128,
    parameter int unsigned A_L    = 40,
    parameter int unsigned TEXT_L = 40,
    parameter int unsigned W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic                 abort_i,
    ascon_serial_engine_if.slave bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 auth_o,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [KEY_L-1:0]     core_key,
    output logic [127:0]         core_nonce,
    output logic [A_L-1:0]       core_ad,
    output logic [TEXT_L-1:0]    core_text,
    output logic [127:0]         core_tag,
    input  logic                 core_done,
    input  logic [TEXT_L-1:0]    core_text_out,
    input  logic [127:0]         core_tag_out,
    input  logic                 core_auth
);

    localparam int unsigned NONCE_L = 128;
    localparam int unsigned TAG_L   = 128;
    localparam int unsigned OUT_L   = TEXT_L + TAG_L;
    localparam int unsigned MAX_1   = (KEY_L > A_L) ? KEY_L : A_L;
    localparam int unsigned MAX_2   = (MAX_1 > TEXT_L) ? MAX_1 : TEXT_L;
    localparam int unsigned MAX_L   = (MAX_2 > TAG_L) ? MAX_2 : TAG_L;
    localparam int unsigned WCNT_W  = $clog2(MAX_L / W + 1);
    localparam int unsigned OCNT_W  = $clog2(OUT_L / W + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, CORE_GO, WAIT_CORE, UNLOAD, DONE
    } state_t;

    typedef enum logic [2:0] {
        F_KEY, F_NONCE, F_AD, F_TEXT, F_TAG
    } field_t;

    state_t              state_q, state_d;
    field_t              field_q;
    logic [WCNT_W-1:0]   word_q;
    logic [OCNT_W-1:0]   out_cnt_q;
    logic [OUT_L-1:0]    out_buf_q;

    logic load_fire, word_end, load_last, out_fire, out_last, abort_act;

    function automatic logic [WCNT_W-1:0] field_words(input field_t f);
        unique case (f)
            F_KEY:   return WCNT_W'(KEY_L / W);
            F_NONCE: return WCNT_W'(NONCE_L / W);
            F_AD:    return WCNT_W'(A_L / W);
            F_TEXT:  return WCNT_W'(TEXT_L / W);
            default: return WCNT_W'(TAG_L / W);
        endcase
    endfunction

    // Handshake strobes and next-state; abort outranks every other event.
    always_comb begin
        abort_act = abort_i && (state_q != IDLE);
        load_fire = bus.in_ready && bus.in_valid;
        word_end  = (word_q == field_words(field_q) - WCNT_W'(1));
        load_last = load_fire && word_end &&
                    (((field_q == F_TEXT) && !core_mode) || (field_q == F_TAG));
        out_fire  = bus.out_valid && bus.out_ready;
        out_last  = out_fire &&
                    (out_cnt_q == (core_mode ? OCNT_W'(TEXT_L / W - 1)
                                             : OCNT_W'(OUT_L / W - 1)));
        state_d   = state_q;
        unique case (state_q)
            IDLE:      if (start_i)   state_d = LOAD;
            LOAD:      if (load_last) state_d = CORE_GO;
            CORE_GO:                  state_d = WAIT_CORE;
            WAIT_CORE: if (core_done) state_d = UNLOAD;
            UNLOAD:    if (out_last)  state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
        if (abort_act) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Registered status/handshake outputs follow the next state directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            core_start    <= 1'b0;
        end else begin
            bus.in_ready  <= (state_d == LOAD);
            bus.out_valid <= (state_d == UNLOAD);
            busy_o        <= (state_d != IDLE);
            done_o        <= (state_d == DONE);
            core_start    <= (state_d == CORE_GO);
        end
    end

    // Field buffers, counters and the output shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            field_q      <= F_KEY;
            word_q       <= '0;
            out_cnt_q    <= '0;
            out_buf_q    <= '0;
            bus.out_data <= '0;
            auth_o       <= 1'b0;
            core_mode    <= 1'b0;
            core_key     <= '0;
            core_nonce   <= '0;
            core_ad      <= '0;
            core_text    <= '0;
            core_tag     <= '0;
        end else if (abort_act) begin
            field_q      <= F_KEY;
            word_q       <= '0;
            out_cnt_q    <= '0;
            bus.out_data <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        core_mode  <= mode_i;
                        auth_o     <= 1'b0;
                        field_q    <= F_KEY;
                        word_q     <= '0;
                        out_cnt_q  <= '0;
                        out_buf_q  <= '0;
                        core_key   <= '0;
                        core_nonce <= '0;
                        core_ad    <= '0;
                        core_text  <= '0;
                        core_tag   <= '0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        // Shift in from the bottom so the first word ends up on top.
                        unique case (field_q)
                            F_KEY:   core_key   <= KEY_L'({core_key, bus.in_data});
                            F_NONCE: core_nonce <= NONCE_L'({core_nonce, bus.in_data});
                            F_AD:    core_ad    <= A_L'({core_ad, bus.in_data});
                            F_TEXT:  core_text  <= TEXT_L'({core_text, bus.in_data});
                            default: core_tag   <= TAG_L'({core_tag, bus.in_data});
                        endcase
                        if (word_end) begin
                            word_q  <= '0;
                            field_q <= field_t'(field_q + 3'd1);
                        end else begin
                            word_q <= word_q + WCNT_W'(1);
                        end
                    end
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        // A failed decrypt tag check replaces the plaintext with ones.
                        out_buf_q    <= {(core_mode && !core_auth) ? {TEXT_L{1'b1}} : core_text_out,
                                         core_tag_out};
                        bus.out_data <= (core_mode && !core_auth) ? {W{1'b1}}
                                                                  : core_text_out[TEXT_L-1 -: W];
                        auth_o       <= core_mode && core_auth;
                        out_cnt_q    <= '0;
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        out_buf_q    <= OUT_L'({out_buf_q, W'(0)});
                        out_cnt_q    <= out_cnt_q + OCNT_W'(1);
                        bus.out_data <= out_last ? '0 : out_buf_q[OUT_L-W-1 -: W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ascon_serial_engine.md
ASCON_SERIAL_ENGINE -- requirements
Module: ascon_serial_engine

Interface
REQ-001 Parameters SHALL be: KEY_L, default 128, key bits; A_L, default 40, associated-data bits; TEXT_L, default 40, plaintext/ciphertext bits; W, default 1, serial lane width in bits (1, 2, 4 or 8).
REQ-002 KEY_L, A_L and TEXT_L SHALL each be an integer multiple of W, with each length >= W; nonce and tag are fixed at 128 bits.
REQ-003 Ports SHALL be, in order: clk in 1 system clock; rst in 1 asynchronous active-low reset.
REQ-004 Ports SHALL include: start_i in 1 start pulse; mode_i in 1 (0 encrypt, 1 decrypt); abort_i in 1 abort.
REQ-005 Ports SHALL include: in_data in W serial input word; in_valid in 1; in_ready out 1.
REQ-006 Ports SHALL include: out_data out W serial output word; out_valid out 1; out_ready in 1.
REQ-007 Ports SHALL include: busy_o out 1; done_o out 1 one-cycle completion pulse; auth_o out 1 decrypt tag match.
REQ-008 Ports SHALL include core side: core_start out 1 pulse; core_mode out 1; core_key out KEY_L; core_nonce out 128; core_ad out A_L; core_text out TEXT_L; core_tag out 128.
REQ-009 Ports SHALL include core return: core_done in 1; core_text_out in TEXT_L; core_tag_out in 128; core_auth in 1.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, CORE_GO, WAIT_CORE, UNLOAD, DONE.
REQ-011 In IDLE, start_i=1 SHALL latch mode_i, clear all field buffers and counters, and enter LOAD next cycle; start_i in any other state SHALL be ignored.
REQ-012 In LOAD, in_ready SHALL be 1; a word transfers only on cycles with in_valid=1 and in_ready=1.
REQ-013 Load order SHALL be key, nonce, AD, text, then tag in decrypt mode only; each field is MSB-first, the first word landing in the field's top W bits.
REQ-014 Load SHALL complete after (KEY_L+128+A_L+TEXT_L)/W transfers in encrypt mode, or that count plus 128/W in decrypt mode; the FSM enters CORE_GO on the cycle after the last transfer.
REQ-015 A field counter and a word counter SHALL track position; the word counter wraps to 0 at each field boundary.
REQ-016 CORE_GO SHALL assert core_start for exactly one cycle and then enter WAIT_CORE; core_key/nonce/ad/text/tag/mode SHALL hold stable from CORE_GO until the engine returns to IDLE.
REQ-017 In WAIT_CORE, core_done=1 SHALL capture core_text_out, core_tag_out and core_auth, then enter UNLOAD; core_done in any other state SHALL be ignored.
REQ-018 UNLOAD in encrypt mode SHALL emit ciphertext (TEXT_L/W words) then tag (128/W words), MSB-first.
REQ-019 UNLOAD in decrypt mode SHALL emit TEXT_L/W words only: plaintext if core_auth=1, otherwise all-ones words.
REQ-020 out_valid SHALL be 1 throughout UNLOAD; out_data SHALL hold its value while out_valid=1 and out_ready=0; the word advances only when out_ready=1.
REQ-021 After the last output handshake, the FSM SHALL enter DONE, pulse done_o for one cycle, and return to IDLE.
REQ-022 auth_o SHALL equal the captured core_auth in decrypt mode and 0 in encrypt mode; it holds until the next start_i accepted in IDLE.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge: in_ready=0, out_valid=0, core_start=0, counters cleared, done_o not pulsed; abort_i has priority over all other events.
REQ-025 If abort_i and start_i are both 1 while in IDLE, start_i SHALL take effect.
REQ-026 The output word SHALL be all-zero whenever out_valid=0.

Reset
REQ-027 On rst=0, asynchronously: state IDLE; in_ready, out_valid, out_data, busy_o, done_o, auth_o and core_start all 0; all core_* buses, buffers and counters 0.
REQ-028 Reset asserted mid-LOAD, mid-WAIT_CORE or mid-UNLOAD SHALL discard the transaction; after rst returns to 1, no output handshake or done_o occurs until a new start_i.

Verification
REQ-029 Encrypt, W=8, defaults, in_valid always 1: exactly 42 input transfers, one core_start; core_done then yields 5 ciphertext words and 16 tag words; done_o pulses once and auth_o=0.
REQ-030 Decrypt with correct tag, W=8: exactly 58 input transfers; core_tag equals the loaded tag; core_auth=1 yields 5 plaintext words and no tag words; auth_o=1.
REQ-031 Decrypt with core_auth=0: 5 words of 8'hFF are emitted; auth_o=0; done_o pulses.
REQ-032 Backpressure and gaps: random in_valid and out_ready at 50%: field contents and output order match the no-stall run, and out_data is stable during every stall.
REQ-033 abort_i during the 20th load transfer, and separately during UNLOAD: IDLE on the next cycle, no done_o; a following transaction completes correctly.
REQ-034 rst=0 pulse during WAIT_CORE followed by core_done=1: the pulse is ignored, all outputs stay at their reset values, and busy_o=0.
